// File: rtl/tx_arb_pkg.sv
// Shared types for the TX burst scheduler.
// State encoding, channel count and a one-hot decode helper.
package tx_arb_pkg;

    localparam int ARB_CHANS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [1:0] onehot_to_idx(
        input logic [ARB_CHANS-1:0] oh
    );
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_CHANS; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tx_burst_scheduler_arbiter.sv
// Round-robin arbiter: grants the first request at or after base.
// base is one-hot; the search wraps from the top channel to channel 0.
module arbiter #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] grant
);

    logic [2*WIDTH-1:0] dbl_req;
    logic [2*WIDTH-1:0] dbl_gnt;

    // Doubled request vector lets the borrow chain wrap past the top.
    always_comb begin
        dbl_req = {req, req};
        dbl_gnt = dbl_req & ~(dbl_req - {{WIDTH{1'b0}}, base});
        grant   = dbl_gnt[WIDTH-1:0] | dbl_gnt[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/tx_burst_scheduler.sv
// Four-channel TX burst scheduler with word quota and stall timeout.
// One bubble cycle separates consecutive grants.
module tx_burst_scheduler
    import tx_arb_pkg::*;
#(
    parameter int NUM_DAT_WORDS = 8,
    parameter int LOG_DAT_WORDS = 4,
    parameter int BURST_WORDS   = 32,
    parameter int IDLE_LIMIT    = 15
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic [3:0]                   chan_valid,
    input  logic [4*LOG_DAT_WORDS-1:0]   chan_num_words,
    input  logic [3:0]                   chan_eop,
    output logic [3:0]                   chan_ready,
    input  logic                         ready,
    output logic [1:0]                   sel,
    output logic                         sel_valid,
    output logic                         burst_end
);

    localparam int CNT_W   = $clog2(BURST_WORDS + NUM_DAT_WORDS + 1);
    localparam int STALL_W = $clog2(IDLE_LIMIT + 1);
    localparam logic [CNT_W-1:0]   QUOTA     = CNT_W'(BURST_WORDS);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(IDLE_LIMIT);

    state_e               state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [1:0]           last_q, last_d;
    logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [LOG_DAT_WORDS-1:0] words [ARB_CHANS];
    logic [ARB_CHANS-1:0]     req, base, grant;
    logic [CNT_W-1:0]         word_sum;
    logic                     live, accept, stall;
    logic                     stall_hit, beat_release;

    // Split per-channel word counts and qualify requests.
    always_comb begin
        for (int n = 0; n < ARB_CHANS; n++) begin
            words[n] = chan_num_words[n*LOG_DAT_WORDS +: LOG_DAT_WORDS];
            req[n]   = chan_valid[n] && (words[n] != '0);
        end
        base = ARB_CHANS'(1) << 2'(last_q + 2'd1);
    end

    arbiter #(
        .WIDTH (ARB_CHANS)
    ) u_arb (
        .req   (req),
        .base  (base),
        .grant (grant)
    );

    // Handshake, beat accounting and release detection for the held grant.
    always_comb begin
        live         = (state_q == HOLD) && ready && !arst;
        chan_ready   = '0;
        chan_ready[sel_q] = live;
        accept       = live && chan_valid[sel_q];
        stall        = live && !chan_valid[sel_q];
        word_sum     = word_cnt_q + CNT_W'(words[sel_q]);
        beat_release = accept && (chan_eop[sel_q] || (word_sum >= QUOTA));
        stall_hit    = stall && ((stall_cnt_q + STALL_W'(1)) == STALL_MAX);
        burst_end    = beat_release;
    end

    // Next-state logic: grant from IDLE, release or count in HOLD.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        word_cnt_d  = word_cnt_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = HOLD;
                    sel_d       = onehot_to_idx(grant);
                    word_cnt_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            HOLD: begin
                if (beat_release || stall_hit) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                end else if (accept) begin
                    word_cnt_d  = word_sum;
                    stall_cnt_d = '0;
                end else if (stall) begin
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            last_q      <= 2'd3;
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = (state_q == HOLD);

endmodule
